decoder_onehot_pipe: RTL and testbench

- Pipelined 3-to-8 one-hot decoder. It is the receive-side counterpart of the team's 8:3 priority encoder: it turns 3-bit indices back into 8-bit one-hot request masks.
- Input and output both use valid/ready handshakes, with a 2-entry output buffer (main + skid).
- Optional accumulate mode ORs a burst of indices into a single mask, emitted on the burst's last beat.
- Sits between the index bus and the request/grant mask consumers.

---
 rtl/decoder_onehot_pipe_if.sv | 28 ++
 rtl/decoder_onehot_pipe.sv | 128 ++++++++++++
 tb/tb_decoder_onehot_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/decoder_onehot_pipe_if.sv
// Index-in / mask-out handshake bundle for the pipelined one-hot decoder.
// master drives beats in and accepts masks out; slave is the decoder.
interface decoder_onehot_pipe_if #(
    parameter int IW = 3,
    parameter int OW = 8,
    parameter int CW = 4
) ();
    logic          en;
    logic          acc_mode;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] din;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] dout;
    logic [CW-1:0] out_cnt;

    modport master (
        output en, acc_mode, in_valid, din, in_last, out_ready,
        input  in_ready, out_valid, dout, out_cnt
    );

    modport slave (
        input  en, acc_mode, in_valid, din, in_last, out_ready,
        output in_ready, out_valid, dout, out_cnt
    );
endinterface

// File: rtl/decoder_onehot_pipe.sv
// Pipelined 3-to-8 one-hot decoder with optional burst accumulation and a
// main + skid output buffer so upstream sees a registered ready.
module decoder_onehot_pipe #(
    parameter int IW = 3,
    parameter int OW = 8,
    parameter int CW = 4
) (
    input logic                 clk,
    input logic                 rst,
    decoder_onehot_pipe_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state, state_nxt;
    logic [OW-1:0] acc_mask, acc_mask_nxt;
    logic [CW-1:0] acc_cnt, acc_cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic [OW-1:0] oh;
    logic          beat;

    logic          emit;
    logic [OW-1:0] emit_mask;
    logic [CW-1:0] emit_cnt;

    logic          main_vld, skid_vld;
    logic [OW-1:0] main_mask, skid_mask;
    logic [CW-1:0] main_cnt, skid_cnt;
    logic          out_xfer;

    // Ready comes straight from the skid flop; rst gates it so upstream
    // never pushes during reset, and it rises the cycle rst drops.
    assign bus.in_ready  = !skid_vld && !rst;
    assign bus.out_valid = main_vld;
    assign bus.dout      = main_mask;
    assign bus.out_cnt   = main_cnt;

    assign beat     = bus.in_valid && bus.in_ready;
    assign out_xfer = main_vld && bus.out_ready;
    assign cnt_inc  = (acc_cnt == CNT_MAX) ? CNT_MAX : acc_cnt + CNT_ONE;

    always_comb begin
        oh = '0;
        if (bus.en) oh[bus.din] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc_mask <= '0;
            acc_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            acc_mask <= acc_mask_nxt;
            acc_cnt  <= acc_cnt_nxt;
        end
    end

    // The ACCUM state is the latched burst mode: acc_mode is only looked at
    // in IDLE, so toggling it mid-burst has no effect.
    always_comb begin
        state_nxt    = state;
        acc_mask_nxt = acc_mask;
        acc_cnt_nxt  = acc_cnt;
        emit         = 1'b0;
        emit_mask    = oh;
        emit_cnt     = CNT_ONE;
        if (beat) begin
            case (state)
                IDLE: begin
                    if (bus.acc_mode && !bus.in_last) begin
                        state_nxt    = ACCUM;
                        acc_mask_nxt = oh;
                        acc_cnt_nxt  = CNT_ONE;
                    end else begin
                        emit = 1'b1;
                    end
                end
                ACCUM: begin
                    if (bus.in_last) begin
                        emit         = 1'b1;
                        emit_mask    = acc_mask | oh;
                        emit_cnt     = cnt_inc;
                        acc_mask_nxt = '0;
                        acc_cnt_nxt  = '0;
                        state_nxt    = IDLE;
                    end else begin
                        acc_mask_nxt = acc_mask | oh;
                        acc_cnt_nxt  = cnt_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Skid full implies in_ready=0, so a skid->main move never coincides
    // with a new emit.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld  <= 1'b0;
            main_mask <= '0;
            main_cnt  <= '0;
            skid_vld  <= 1'b0;
            skid_mask <= '0;
            skid_cnt  <= '0;
        end else if (!main_vld || out_xfer) begin
            if (skid_vld) begin
                main_vld  <= 1'b1;
                main_mask <= skid_mask;
                main_cnt  <= skid_cnt;
                skid_vld  <= 1'b0;
            end else if (emit) begin
                main_vld  <= 1'b1;
                main_mask <= emit_mask;
                main_cnt  <= emit_cnt;
            end else begin
                main_vld  <= 1'b0;
            end
        end else if (emit) begin
            skid_vld  <= 1'b1;
            skid_mask <= emit_mask;
            skid_cnt  <= emit_cnt;
        end
    end
endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Directed + random bench for decoder_onehot_pipe against a queue-based
// model of emitted masks and the burst accumulator.
module tb_decoder_onehot_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decoder_onehot_pipe_if #(.IW(3), .OW(8), .CW(4)) bus ();

    decoder_onehot_pipe #(.IW(3), .OW(8), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] m;
        logic [3:0] c;
    } ent_t;

    ent_t q[$];
    bit   m_active;
    int   m_mask;
    int   m_cnt;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input int d, input bit e, input bit l, input bit a);
        int   oh;
        ent_t t;
        oh = e ? (1 << d) : 0;
        if (!m_active) begin
            if (!a || l) begin
                t.m = 8'(oh); t.c = 4'd1; q.push_back(t);
            end else begin
                m_active = 1; m_mask = oh; m_cnt = 1;
            end
        end else begin
            m_mask = m_mask | oh;
            m_cnt  = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
            if (l) begin
                t.m = 8'(m_mask); t.c = 4'(m_cnt); q.push_back(t);
                m_active = 0; m_mask = 0; m_cnt = 0;
            end
        end
    endtask

    // One clock: drive, check at negedge, update model at posedge.
    task automatic cyc(input bit r, input bit v, input int d, input bit e,
                       input bit l, input bit a, input bit o, output bit accepted);
        bit pop;
        rst           = r;
        bus.in_valid  = v;
        bus.din       = 3'(d);
        bus.en        = e;
        bus.in_last   = l;
        bus.acc_mode  = a;
        bus.out_ready = o;
        @(negedge clk);
        if (r) begin
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        end else begin
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("dout", 32'(bus.dout), 32'(q[0].m));
                chk("out_cnt", 32'(bus.out_cnt), 32'(q[0].c));
            end
        end
        accepted = !r && v && (q.size() < 2);
        pop      = !r && o && (q.size() > 0);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_active = 0; m_mask = 0; m_cnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (accepted) model_beat(d, e, l, a);
        end
        #1;
        if (r) begin
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_dout", 32'(bus.dout), 32'd0);
            chk("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 1, acc);
    endtask

    initial begin
        bit acc;
        int guard;
        cyc(1, 0, 0, 1, 0, 0, 1, acc);
        cyc(1, 0, 0, 1, 0, 0, 1, acc);

        // back-to-back single decode, in_ready must stay high
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, i, 1, 0, 0, 1, acc);
            chk("stream_dout", 32'(bus.dout), 32'(1 << i));
            chk("stream_cnt", 32'(bus.out_cnt), 32'd1);
        end
        cyc(0, 1, 5, 0, 0, 0, 1, acc);
        chk("en0_dout", 32'(bus.dout), 32'h00);
        cyc(0, 1, 5, 1, 0, 0, 1, acc);
        chk("en1_dout", 32'(bus.dout), 32'h20);
        idle(2);

        // backpressure fills main + skid, third beat stalls
        cyc(0, 1, 1, 1, 0, 0, 0, acc);
        cyc(0, 1, 2, 1, 0, 0, 0, acc);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 3, 1, 0, 0, 0, acc);
            chk("bp_hold_dout", 32'(bus.dout), 32'h02);
        end
        guard = 0;
        acc = 0;
        while (!acc && guard < 20) begin
            cyc(0, 1, 3, 1, 0, 0, 1, acc);
            guard++;
        end
        chk("bp_accept_timeout", 32'(acc), 32'd1);
        idle(4);

        // accumulate 1,4,(1 en=0),6 -> 0x52 / 4
        cyc(0, 1, 1, 1, 0, 1, 1, acc);
        cyc(0, 1, 4, 1, 0, 1, 1, acc);
        cyc(0, 1, 1, 0, 0, 1, 1, acc);
        cyc(0, 1, 6, 1, 1, 1, 1, acc);
        chk("acc_dout", 32'(bus.dout), 32'h52);
        chk("acc_cnt", 32'(bus.out_cnt), 32'd4);
        idle(2);

        // 20-beat burst saturates; acc_mode dropped mid-burst
        for (int i = 0; i < 20; i++)
            cyc(0, 1, 0, 1, (i == 19), (i < 10), 1, acc);
        chk("sat_dout", 32'(bus.dout), 32'h01);
        chk("sat_cnt", 32'(bus.out_cnt), 32'd15);
        idle(2);

        // reset mid-burst discards partial burst
        cyc(0, 1, 2, 1, 0, 1, 1, acc);
        cyc(0, 1, 3, 1, 0, 1, 1, acc);
        cyc(1, 0, 0, 1, 0, 1, 1, acc);
        idle(1);
        cyc(0, 1, 7, 1, 1, 1, 1, acc);
        chk("post_rst_dout", 32'(bus.dout), 32'h80);
        chk("post_rst_cnt", 32'(bus.out_cnt), 32'd1);
        idle(2);

        // random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 2) != 0), acc);
        end
        idle(6);
        chk("drain_empty", 32'(bus.out_valid), 32'(q.size() > 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
